bits32_mux_arbiter: RTL and testbench

BITS32_MUX_ARBITER -- requirements
Module: bits32_mux_arbiter

---
 rtl/bits32_mux_arbiter_pkg.sv | 15 +
 rtl/bits32_mux_arbiter_mux.sv | 12 +
 rtl/bits32_mux_arbiter.sv | 88 ++++++++
 tb/tb_bits32_mux_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bits32_mux_arbiter_pkg.sv
// Shared definitions for the two-requester 32-bit mux arbiter:
// output-register FSM encodings, requester indices and datapath width.
package bits32_mux_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/bits32_mux_arbiter_mux.sv
// Plain 32-bit 2:1 multiplexer: Output = Select ? Input1 : Input0.
// Purely combinational; no state, no flow control.
module bits32mux2to1 (
  input  logic [31:0] Input0,
  input  logic [31:0] Input1,
  input  logic        Select,
  output logic [31:0] Output
);

  assign Output = Select ? Input1 : Input0;

endmodule

// File: rtl/bits32_mux_arbiter.sv
// Round-robin arbiter between two 32-bit requesters into one registered output slot; 1-cycle latency.
// Readys drop whenever the slot is full and the consumer stalls; a draining slot reloads on the same edge.
module bits32_mux_arbiter
  import bits32_mux_arbiter_pkg::*;
#(
  parameter logic FIRST_PRIO = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] In0Data,
  input  logic              In0Valid,
  output logic              In0Ready,
  input  logic [DATA_W-1:0] In1Data,
  input  logic              In1Valid,
  output logic              In1Ready,
  output logic [DATA_W-1:0] Out,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              OutSrc
);

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              src_q, src_d;

  logic              can_load;
  logic              gnt0, gnt1, gnt_vld, gnt_idx;
  logic [DATA_W-1:0] mux_dat;

  // Reset gates the grants so no input transfer is reported while it is held.
  always_comb begin
    can_load = (state_q == ST_EMPTY) || OutReady;
    gnt0     = !Reset && can_load && In0Valid && (!In1Valid || (ptr_q == REQ0));
    gnt1     = !Reset && can_load && In1Valid && (!In0Valid || (ptr_q == REQ1));
    gnt_vld  = gnt0 || gnt1;
    gnt_idx  = gnt1 ? REQ1 : REQ0;
  end

  bits32mux2to1 u_mux (
    .Input0 (In0Data),
    .Input1 (In1Data),
    .Select (gnt_idx),
    .Output (mux_dat)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    out_d   = out_q;
    src_d   = src_q;
    case (state_q)
      ST_EMPTY: begin
        if (gnt_vld) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (OutReady && !gnt_vld) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (gnt_vld) begin
      out_d = mux_dat;
      src_d = gnt_idx;
      ptr_d = ~gnt_idx;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_EMPTY;
      ptr_q   <= FIRST_PRIO;
      out_q   <= '0;
      src_q   <= REQ0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
      src_q   <= src_d;
    end
  end

  assign In0Ready = gnt0;
  assign In1Ready = gnt1;
  assign Out      = out_q;
  assign OutValid = (state_q == ST_FULL);
  assign OutSrc   = src_q;

endmodule

// File: tb/tb_bits32_mux_arbiter.sv
// Bench for bits32_mux_arbiter: two instances (FIRST_PRIO 0 and 1) share stimulus,
// a per-cycle reference model plus directed literal checks.
module tb_bits32_mux_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] d0, d1;
  logic        v0, v1, oready;

  logic [31:0] o_dat [2];
  logic        o_vld [2];
  logic        o_src [2];
  logic        r0    [2];
  logic        r1    [2];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  bits32_mux_arbiter #(.FIRST_PRIO(1'b0)) dut0 (
    .Clk(clk), .Reset(rst),
    .In0Data(d0), .In0Valid(v0), .In0Ready(r0[0]),
    .In1Data(d1), .In1Valid(v1), .In1Ready(r1[0]),
    .Out(o_dat[0]), .OutValid(o_vld[0]), .OutReady(oready), .OutSrc(o_src[0])
  );

  bits32_mux_arbiter #(.FIRST_PRIO(1'b1)) dut1 (
    .Clk(clk), .Reset(rst),
    .In0Data(d0), .In0Valid(v0), .In0Ready(r0[1]),
    .In1Data(d1), .In1Valid(v1), .In1Ready(r1[1]),
    .Out(o_dat[1]), .OutValid(o_vld[1]), .OutReady(oready), .OutSrc(o_src[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one holding slot per instance, plus whose turn it is on a tie.
  bit          m_full [2];
  logic [31:0] m_word [2];
  int          m_src  [2];
  int          m_turn [2];

  function automatic int m_grant(int k);
    if (m_full[k] && !oready) return -1;
    if (v0 && v1) return m_turn[k];
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic void m_step(int k);
    int g;
    g = m_grant(k);
    if (g >= 0) begin
      m_full[k] = 1'b1;
      m_word[k] = (g == 1) ? d1 : d0;
      m_src[k]  = g;
      m_turn[k] = 1 - g;
    end else if (m_full[k] && oready) begin
      m_full[k] = 1'b0;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_full[k] = 1'b0;
        m_word[k] = 32'h0;
        m_src[k]  = 0;
        m_turn[k] = k;
      end else begin
        m_step(k);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        int g;
        g = m_grant(k);
        check($sformatf("u%0d.In0Ready", k), 32'(r0[k]), 32'(!rst && g == 0));
        check($sformatf("u%0d.In1Ready", k), 32'(r1[k]), 32'(!rst && g == 1));
        check($sformatf("u%0d.OutValid", k), 32'(o_vld[k]), 32'(m_full[k]));
        if (m_full[k]) begin
          check($sformatf("u%0d.Out", k), o_dat[k], m_word[k]);
          check($sformatf("u%0d.OutSrc", k), 32'(o_src[k]), 32'(m_src[k]));
        end
      end
    end
  end

  task automatic drv_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_slot();
    @(negedge clk);
    #1;
  endtask

  // Assert reset between edges, check the forced values, release just after an edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    v0 = 1'b0; v1 = 1'b0; oready = 1'b0; d0 = 32'h0; d1 = 32'h0;
    rst = 1'b1;
    #1;
    check("rst.OutValid", 32'(o_vld[0]), 32'h0);
    check("rst.Out", o_dat[0], 32'h0);
    chk_en = 1'b1;
    drv_slot();
    rst = 1'b0;
  endtask

  logic [31:0] seq_exp [4];

  initial begin
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0; oready = 1'b0; d0 = 32'h0; d1 = 32'h0;
    seq_exp[0] = 32'h1; seq_exp[1] = 32'h2; seq_exp[2] = 32'h1; seq_exp[3] = 32'h2;

    // Single requester 0, one-cycle latency.
    do_reset();
    v0 = 1'b1; d0 = 32'hA5A5A5A5; oready = 1'b1;
    chk_slot();
    check("a5.In0Ready", 32'(r0[0]), 32'h1);
    check("a5.In1Ready", 32'(r1[0]), 32'h0);
    drv_slot();
    v0 = 1'b0;
    chk_slot();
    check("a5.Out", o_dat[0], 32'hA5A5A5A5);
    check("a5.OutValid", 32'(o_vld[0]), 32'h1);
    check("a5.OutSrc", 32'(o_src[0]), 32'h0);

    // Both valid, full throughput alternation.
    do_reset();
    v0 = 1'b1; v1 = 1'b1; d0 = 32'h1; d1 = 32'h2; oready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drv_slot();
      chk_slot();
      check($sformatf("rr%0d.Out", i), o_dat[0], seq_exp[i]);
      check($sformatf("rr%0d.OutSrc", i), 32'(o_src[0]), 32'(i % 2));
    end

    // Stall for five cycles, then drain and reload on the same edge.
    drv_slot();
    oready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_slot();
      check($sformatf("stall%0d.Out", i), o_dat[0], 32'h1);
      check($sformatf("stall%0d.OutSrc", i), 32'(o_src[0]), 32'h0);
      check($sformatf("stall%0d.rdy", i), 32'({r0[0], r1[0]}), 32'h0);
    end
    drv_slot();
    oready = 1'b1;
    chk_slot();
    check("unstall.In1Ready", 32'(r1[0]), 32'h1);
    check("unstall.In0Ready", 32'(r0[0]), 32'h0);
    drv_slot();
    chk_slot();
    check("unstall.Out", o_dat[0], 32'h2);
    check("unstall.OutSrc", 32'(o_src[0]), 32'h1);
    check("unstall.OutValid", 32'(o_vld[0]), 32'h1);

    // Requester 1 alone three times, then requester 0 wins the tie.
    do_reset();
    v1 = 1'b1; d1 = 32'hFFFFFFFF; d0 = 32'h00000C0C; oready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv_slot();
      chk_slot();
      check($sformatf("solo%0d.Out", i), o_dat[0], 32'hFFFFFFFF);
      check($sformatf("solo%0d.OutSrc", i), 32'(o_src[0]), 32'h1);
    end
    v0 = 1'b1;
    #1;
    check("solo.tie.In0Ready", 32'(r0[0]), 32'h1);
    check("solo.tie.In1Ready", 32'(r1[0]), 32'h0);
    drv_slot();
    chk_slot();
    check("solo.tie.Out", o_dat[0], 32'h00000C0C);
    check("solo.tie.OutSrc", 32'(o_src[0]), 32'h0);

    // Asynchronous reset while full discards the word immediately.
    do_reset();
    v0 = 1'b1; d0 = 32'h12345678; d1 = 32'h87654321; oready = 1'b1;
    drv_slot();
    v0 = 1'b0; oready = 1'b0;
    chk_slot();
    check("ar.pre.Out", o_dat[0], 32'h12345678);
    v0 = 1'b1; v1 = 1'b1; oready = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("ar.OutValid", 32'(o_vld[0]), 32'h0);
    check("ar.Out", o_dat[0], 32'h0);
    check("ar.OutSrc", 32'(o_src[0]), 32'h0);
    check("ar.rdy", 32'({r0[0], r1[0], r0[1], r1[1]}), 32'h0);
    drv_slot();
    rst = 1'b0;
    chk_slot();
    check("ar.u0.In0Ready", 32'(r0[0]), 32'h1);
    check("ar.u1.In1Ready", 32'(r1[1]), 32'h1);
    drv_slot();
    chk_slot();
    check("ar.u0.Out", o_dat[0], 32'h12345678);
    check("ar.u1.Out", o_dat[1], 32'h87654321);
    check("ar.u1.OutSrc", 32'(o_src[1]), 32'h1);

    v0 = 1'b0; v1 = 1'b0;
    drv_slot();
    drv_slot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
